// File: rtl/piso_tx_ctrl.sv
// rtl/piso_tx_ctrl.sv - MSB-first PISO transmit sequencer with load/shift strobes (optional PISO_TX_PARITY_EN)
module piso_tx_ctrl #(
    parameter int WIDTH      = 4,
    parameter int BIT_DIV    = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             sr_load,
    output logic             sr_shift,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
`ifdef PISO_TX_PARITY_EN
        ,
        S_PAR   = 2'd3
`endif
    } state_t;

    state_t           state;
    state_t           state_nxt;
    state_t           after_frame;
    logic [WIDTH-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             bit_tick;
    logic             last_bit;
`ifdef PISO_TX_PARITY_EN
    logic             parity;
`endif

    assign bit_tick    = (div_cnt == DIV_LAST);
    assign last_bit    = (bit_cnt == BIT_LAST);
    assign after_frame = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state != S_GAP) begin
                gap_cnt <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg   <= in_data;
                        bit_cnt <= '0;
                        div_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
                        parity  <= ^in_data;
`endif
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                    end else if (bit_tick) begin
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
`ifdef PISO_TX_PARITY_EN
                S_PAR: begin
                    if (abort) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                    end else if (bit_tick) begin
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
`endif
                S_GAP: begin
                    if (abort) begin
                        shreg <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (bit_tick && last_bit) begin
`ifdef PISO_TX_PARITY_EN
                    state_nxt = S_PAR;
`else
                    state_nxt = after_frame;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            S_PAR: begin
                if (abort) state_nxt = S_IDLE;
                else if (bit_tick) state_nxt = after_frame;
            end
`endif
            S_GAP: begin
                if (abort || gap_cnt == GAP_LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes are combinational so an external PISO sees them on the same edge as shreg.
    always_comb begin
        in_ready  = 1'b0;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                sr_load  = in_valid && !rst;
            end
            S_SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg[WIDTH-1];
                busy      = 1'b1;
                sr_shift  = bit_tick && !abort;
`ifndef PISO_TX_PARITY_EN
                done      = bit_tick && last_bit && !abort;
`endif
            end
`ifdef PISO_TX_PARITY_EN
            S_PAR: begin
                ser_valid = 1'b1;
                ser_out   = parity;
                busy      = 1'b1;
                done      = bit_tick && !abort;
            end
`endif
            S_GAP: begin
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb/tb_piso_tx_ctrl.sv - self-checking bench for piso_tx_ctrl (three parameter sets, shared stimulus)
module tb_piso_tx_ctrl;

    localparam int W = 4;
    localparam int DV [3] = '{1, 3, 1};
    localparam int GV [3] = '{1, 1, 0};
`ifdef PISO_TX_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         abort;
    logic [2:0]   in_ready, ser_out, ser_valid, sr_load, sr_shift, busy, done;

    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    piso_tx_ctrl #(.WIDTH(W), .BIT_DIV(1), .GAP_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[0]),
        .abort(abort), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .sr_load(sr_load[0]),
        .sr_shift(sr_shift[0]), .busy(busy[0]), .done(done[0]));

    piso_tx_ctrl #(.WIDTH(W), .BIT_DIV(3), .GAP_CYCLES(1)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[1]),
        .abort(abort), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .sr_load(sr_load[1]),
        .sr_shift(sr_shift[1]), .busy(busy[1]), .done(done[1]));

    piso_tx_ctrl #(.WIDTH(W), .BIT_DIV(1), .GAP_CYCLES(0)) u_c (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[2]),
        .abort(abort), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]), .sr_load(sr_load[2]),
        .sr_shift(sr_shift[2]), .busy(busy[2]), .done(done[2]));

    // Output vector order: {in_ready, sr_load, ser_valid, ser_out, sr_shift, busy, done}
    function automatic logic [6:0] dut_out(input int i);
        return {in_ready[i], sr_load[i], ser_valid[i], ser_out[i], sr_shift[i], busy[i], done[i]};
    endfunction

    // Reference: a frame is "active" with phase p counted from the transfer cycle.
    logic         m_act  [3];
    int           m_p    [3];
    logic [W-1:0] m_word [3];

    function automatic logic [6:0] expect_out(input int i);
        logic [6:0] e;
        int d, k;
        d = DV[i];
        e = '0;
        if (!m_act[i]) begin
            e[6] = 1'b1;
            e[5] = in_valid;
        end else begin
            e[1] = 1'b1;
            if (m_p[i] <= FB * d) begin
                k    = (m_p[i] - 1) / d;
                e[4] = 1'b1;
                e[3] = (k < W) ? m_word[i][W-1-k] : ^m_word[i];
                if (!abort) begin
                    e[2] = (m_p[i] % d == 0) && (k < W);
                    e[0] = (m_p[i] == FB * d);
                end
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_act[i] = 1'b0;
            end else if (!m_act[i]) begin
                if (in_valid) begin
                    m_act[i]  = 1'b1;
                    m_p[i]    = 1;
                    m_word[i] = in_data;
                end
            end else if (abort || m_p[i] == FB * DV[i] + GV[i]) begin
                m_act[i] = 1'b0;
            end else begin
                m_p[i] = m_p[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int i = 0; i < 3; i++) begin
                logic [6:0] e;
                e = expect_out(i);
                checks++;
                if (dut_out(i) !== e) begin
                    failures++;
                    $display("FAIL model_dut%0d t=%0t got=%b want=%b", i, $time, dut_out(i), e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic ab, input logic r);
        in_valid = v;
        in_data  = d;
        abort    = ab;
        rst      = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         ab;
        logic [6:0]   exp;
    } vec_t;

    initial begin
        vec_t tbl [9];
        logic [W-1:0] wa, wb;

        drive(1'b0, '0, 1'b0, 1'b1);
        repeat (3) tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        mid();
        chk("reset_state_a", int'(dut_out(0)), int'(7'b1000000));
        chk("reset_state_b", int'(dut_out(1)), int'(7'b1000000));
        mon_en = 1'b1;

`ifndef PISO_TX_PARITY_EN
        tbl[0] = '{1'b1, 4'b1011, 1'b0, 7'b1100000};
        tbl[1] = '{1'b0, 4'b0000, 1'b0, 7'b0011110};
        tbl[2] = '{1'b1, 4'b0000, 1'b0, 7'b0010110};
        tbl[3] = '{1'b1, 4'b0000, 1'b0, 7'b0011110};
        tbl[4] = '{1'b0, 4'b0000, 1'b0, 7'b0011111};
        tbl[5] = '{1'b0, 4'b0000, 1'b0, 7'b0000010};
        tbl[6] = '{1'b0, 4'b0000, 1'b0, 7'b1000000};
        tbl[7] = '{1'b1, 4'b0101, 1'b1, 7'b1100000};
        tbl[8] = '{1'b0, 4'b0000, 1'b0, 7'b0010110};
        tick();
        for (int c = 0; c < 9; c++) begin
            drive(tbl[c].v, tbl[c].d, tbl[c].ab, 1'b0);
            mid();
            chk($sformatf("table_c%0d", c), int'(dut_out(0)), int'(tbl[c].exp));
            tick();
        end

        // Slow bit rate on u_b
        idle(20);
        drive(1'b1, 4'b1001, 1'b0, 1'b0);
        mid();
        chk("div3_load", int'(sr_load[1]), 1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            mid();
            chk($sformatf("div3_ser_c%0d", c), int'(ser_out[1]), int'(c <= 3 || c >= 10));
            chk($sformatf("div3_done_c%0d", c), int'(done[1]), int'(c == 12));
            tick();
        end

        // Back-to-back on u_c (no gap) with in_valid held
        idle(20);
        wa = 4'hA;
        wb = 4'h5;
        drive(1'b1, wa, 1'b0, 1'b0);
        tick();
        drive(1'b1, wb, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            mid();
            if (c == 5) begin
                chk("b2b_bubble_valid", int'(ser_valid[2]), 0);
                chk("b2b_second_load", int'(sr_load[2]), 1);
            end else begin
                chk($sformatf("b2b_ser_c%0d", c), int'(ser_out[2]), int'(c < 5 ? wa[4-c] : wb[9-c]));
            end
            chk($sformatf("b2b_done_c%0d", c), int'(done[2]), int'(c == 4 || c == 9));
            tick();
            if (c == 5) drive(1'b0, '0, 1'b0, 1'b0);
        end

        // Abort during bit 2 on u_a, then a clean frame
        idle(20);
        drive(1'b1, 4'hF, 1'b0, 1'b0);
        tick();
        idle(2);
        drive(1'b0, '0, 1'b1, 1'b0);
        mid();
        chk("abort_no_shift", int'(sr_shift[0]), 0);
        chk("abort_no_done", int'(done[0]), 0);
        tick();
        drive(1'b1, 4'h3, 1'b0, 1'b0);
        mid();
        chk("abort_valid_low", int'(ser_valid[0]), 0);
        chk("abort_ready_high", int'(in_ready[0]), 1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            mid();
            chk($sformatf("after_abort_ser_c%0d", c), int'(ser_out[0]), int'(c >= 3));
            chk($sformatf("after_abort_done_c%0d", c), int'(done[0]), int'(c == 4));
            tick();
        end
`else
        idle(20);
        wa = 4'b0111;
        wb = 4'b0110;
        drive(1'b1, wa, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            mid();
            chk($sformatf("par_ser_c%0d", c), int'(ser_out[0]), int'(c == 5 ? 1'b1 : wa[4-c]));
            chk($sformatf("par_done_c%0d", c), int'(done[0]), int'(c == 5));
            tick();
        end
        idle(20);
        drive(1'b1, wb, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (4) tick();
        mid();
        chk("par_bit_zero", int'(ser_out[0]), 0);
        chk("par_no_shift", int'(sr_shift[0]), 0);
        tick();
`endif

        // Reset mid-frame with in_valid high during reset
        idle(20);
        drive(1'b1, 4'hF, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'hF, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        mid();
        for (int i = 0; i < 3; i++) chk($sformatf("rst_mid_dut%0d", i), int'(dut_out(i)), int'(7'b1000000));
        tick();
        mid();
        chk("rst_no_accept", int'(ser_valid[0]), 0);
        tick();

        // Randomized traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 99) == 0);
            tick();
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_tx_ctrl.md
Name: piso_tx_ctrl

Overview:
Sequencer for a WIDTH-bit parallel-in/serial-out shift path. Accepts parallel words over a valid/ready handshake, loads an internal shift register, and shifts the word out MSB first at a programmable bit rate, with an inter-frame gap. Exports load/shift strobes so an external gate-level PISO (SR flip-flop based) can be driven in lockstep with the internal copy.

Parameters:
WIDTH, 4, data word width in bits (>=2)
BIT_DIV, 1, clock cycles per serial bit (>=1)
GAP_CYCLES, 1, idle cycles after each frame before in_ready reasserts (>=0)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_data  input  WIDTH  parallel word to transmit
in_valid  input  1  in_data is valid
in_ready  output  1  controller can accept a word
abort  input  1  cancel current frame
ser_out  output  1  serial data, MSB first
ser_valid  output  1  ser_out carries a frame bit
sr_load  output  1  load strobe for external PISO
sr_shift  output  1  shift strobe for external PISO
busy  output  1  frame or gap in progress
done  output  1  one-cycle pulse when a frame completes normally

Behaviour:
- One clock. Reset is synchronous and active-high. rst wins over every other input.
- Reset values: state=IDLE, shift reg=0, counters=0, in_ready=1, ser_out=0, ser_valid=0, sr_load=0, sr_shift=0, busy=0, done=0.
- Transfer occurs when in_valid && in_ready. in_ready=1 only in IDLE. in_valid outside IDLE is ignored and has no side effects.
- States: IDLE, SHIFT, PAR (only with the optional feature), GAP.
- IDLE:
  - sr_load = in_valid (combinational).
  - On transfer: shreg<=in_data, bit_cnt<=0, div_cnt<=0, next state SHIFT.
- SHIFT:
  - ser_valid=1, ser_out=shreg[WIDTH-1], busy=1.
  - div_cnt counts 0..BIT_DIV-1. At div_cnt==BIT_DIV-1: sr_shift=1 (combinational), shreg shifts left with zero fill, bit_cnt++, div_cnt<=0.
  - At that terminal count with bit_cnt==WIDTH-1: done=1 in the same cycle. Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - ser_valid=0, ser_out=0, busy=1.
  - Stays GAP_CYCLES cycles, then IDLE.
- Latency: transfer at cycle 0, bit k (k=0 is MSB) valid on cycles 1+k*BIT_DIV .. (k+1)*BIT_DIV.
  - done is on cycle WIDTH*BIT_DIV.
  - in_ready is high again on cycle WIDTH*BIT_DIV+GAP_CYCLES+1.
- Back-to-back: with GAP_CYCLES=0, a new word may transfer on the cycle after done, giving a one-cycle ser_valid=0 bubble.
- abort in SHIFT, PAR or GAP: next state IDLE, shreg cleared, no done, no sr_shift that cycle. abort in IDLE is ignored, and abort has priority over a simultaneous transfer only if the state is not IDLE.
- rst mid-frame: all reset values on the next edge. The partial frame is discarded.
- sr_load and sr_shift are never high in the same cycle.

Optional Feature:
- Macro PISO_TX_PARITY_EN.
- Defined:
  - Even parity of in_data is registered at transfer.
  - After the last data bit, state PAR drives ser_out=parity, ser_valid=1 for BIT_DIV cycles, with sr_shift=0.
  - done moves to the final PAR cycle. All later timing shifts by BIT_DIV.
- Undefined: PAR state and parity register are absent. Frame is WIDTH bits.

Test Plan:
1. WIDTH=4, BIT_DIV=1, GAP=1. Reset, then in_data=4'b1011 valid at cycle 0 -> sr_load=1 at cycle 0; ser_out 1,0,1,1 on cycles 1-4; sr_shift=1 cycles 1-4; done at cycle 4; in_ready=0 cycles 1-5, high at cycle 6.
2. BIT_DIV=3, in_data=4'b1001 -> each bit held 3 cycles (1 on cycles 1-3, 0 on cycles 4-9, 1 on cycles 10-12); done at cycle 12.
3. GAP=0, in_valid held high with words 4'hA then 4'h5 -> second transfer at cycle 5; stream 1010, bubble, 0101; two done pulses at cycles 4 and 9.
4. abort asserted during bit 2 of 4'hF -> ser_valid=0 next cycle, no done, in_ready=1 next cycle; a following 4'h3 transmits 0011 cleanly.
5. rst asserted mid-frame -> all outputs at reset values after the edge; in_valid during rst is not accepted.
6. PISO_TX_PARITY_EN defined, in_data=4'b0111 -> ser_out 0,1,1,1,1 (parity=1) on cycles 1-5; done at cycle 5. For in_data=4'b0110 the parity bit is 0.
